// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, ALU operation encodings, control bundle
// and the bubble value loaded into EX when no instruction advances.
package isa_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_RED    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [3:0] ALU_RED    = 4'b0000;
  localparam logic [3:0] ALU_SRA    = 4'b0001;
  localparam logic [3:0] ALU_ROR    = 4'b0010;
  localparam logic [3:0] ALU_PADDSB = 4'b0011;
  localparam logic [3:0] ALU_SLL    = 4'b0100;
  localparam logic [3:0] ALU_LW     = 4'b0101;
  localparam logic [3:0] ALU_SW     = 4'b0110;
  localparam logic [3:0] ALU_LHB    = 4'b0111;
  localparam logic [3:0] ALU_LLB    = 4'b1000;
  localparam logic [3:0] ALU_ADD    = 4'b1001;
  localparam logic [3:0] ALU_SUB    = 4'b1010;
  localparam logic [3:0] ALU_XOR    = 4'b1011;
  localparam logic [3:0] ALU_NONE   = 4'b1111;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       flag_write;
    logic       imm;
    logic       shift;
    logic       branch;
    logic       br;
    logic       pcs;
    logic       hlt;
  } ctrl_t;

  // No-op control word: ALU idle, nothing written, nothing accessed.
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'({ALU_NONE, 11'b0});

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode -> control table, plus whether rt is a real source.
module ctrl_decode
  import isa_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl,
  output logic       uses_rt
);

  // Start from the bubble word and raise only the controls each opcode needs.
  always_comb begin
    ctrl    = CTRL_BUBBLE;
    uses_rt = 1'b0;
    case (opcode)
      OP_ADD:    begin ctrl.alu_op = ALU_ADD; ctrl.reg_write = 1'b1; ctrl.flag_write = 1'b1; uses_rt = 1'b1; end
      OP_SUB:    begin ctrl.alu_op = ALU_SUB; ctrl.reg_write = 1'b1; ctrl.flag_write = 1'b1; uses_rt = 1'b1; end
      OP_RED:    begin ctrl.alu_op = ALU_RED; ctrl.reg_write = 1'b1; uses_rt = 1'b1; end
      OP_XOR:    begin ctrl.alu_op = ALU_XOR; ctrl.reg_write = 1'b1; ctrl.flag_write = 1'b1; uses_rt = 1'b1; end
      OP_SLL:    begin
        ctrl.alu_op = ALU_SLL; ctrl.reg_write = 1'b1; ctrl.flag_write = 1'b1;
        ctrl.imm = 1'b1; ctrl.shift = 1'b1;
      end
      OP_SRA:    begin
        ctrl.alu_op = ALU_SRA; ctrl.reg_write = 1'b1; ctrl.flag_write = 1'b1;
        ctrl.imm = 1'b1; ctrl.shift = 1'b1;
      end
      OP_ROR:    begin
        ctrl.alu_op = ALU_ROR; ctrl.reg_write = 1'b1; ctrl.flag_write = 1'b1;
        ctrl.imm = 1'b1; ctrl.shift = 1'b1;
      end
      OP_PADDSB: begin ctrl.alu_op = ALU_PADDSB; ctrl.reg_write = 1'b1; uses_rt = 1'b1; end
      OP_LW:     begin
        ctrl.alu_op = ALU_LW; ctrl.reg_write = 1'b1; ctrl.imm = 1'b1; ctrl.shift = 1'b1;
        ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1;
      end
      // Store reads rt as the data to write, so it is a true source.
      OP_SW:     begin ctrl.alu_op = ALU_SW; ctrl.imm = 1'b1; ctrl.mem_write = 1'b1; uses_rt = 1'b1; end
      OP_LHB:    begin ctrl.alu_op = ALU_LHB; ctrl.reg_write = 1'b1; ctrl.imm = 1'b1; end
      OP_LLB:    begin ctrl.alu_op = ALU_LLB; ctrl.reg_write = 1'b1; ctrl.imm = 1'b1; end
      OP_B:      ctrl.branch = 1'b1;
      OP_BR:     ctrl.br = 1'b1;
      OP_PCS:    begin ctrl.reg_write = 1'b1; ctrl.pcs = 1'b1; end
      OP_HLT:    ctrl.hlt = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// ID->EX control pipeline register with load-use hazard detection,
// sticky halt and a saturating count of inserted hazard bubbles.
module decode_ctrl_pipe
  import isa_pkg::*;
#(
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16,
  parameter int HAZ_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       opcode,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  input  logic             stall_ext,
  input  logic             flush,
  output logic             stall_id,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_op,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_flag_write,
  output logic             ex_imm,
  output logic             ex_shift,
  output logic             ex_branch,
  output logic             ex_br,
  output logic             ex_pcs,
  output logic             ex_hlt,
  output logic [REG_W-1:0] ex_rd,
  output logic             halted,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  uses_rt;
  logic  hazard;

  ctrl_decode u_dec (
    .opcode  (opcode),
    .ctrl    (id_ctrl),
    .uses_rt (uses_rt)
  );

  // Load in EX whose result a dependent ID instruction needs; r0 is never a hazard.
  generate
    if (HAZ_EN != 0) begin : g_haz
      assign hazard = id_valid & ex_valid & ex_ctrl.mem_read & (ex_rd != '0) &
                      ((rs == ex_rd) | (uses_rt & (rt == ex_rd))) & ~halted;
    end else begin : g_no_haz
      assign hazard = 1'b0;
    end
  endgenerate

  // A flushed ID instruction is dead, so it must not hold fetch.
  assign stall_id = hazard & ~flush;

  // EX register update: stall_ext freezes everything; otherwise bubble or load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= CTRL_BUBBLE;
      ex_rd      <= '0;
      halted     <= 1'b0;
      bubble_cnt <= '0;
    end else if (!stall_ext) begin
      if (flush || halted || hazard || !id_valid) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= CTRL_BUBBLE;
        ex_rd    <= '0;
        // Only a bubble inserted for a hazard counts; flush outranks it.
        if (hazard && !flush && bubble_cnt != '1)
          bubble_cnt <= bubble_cnt + CNT_ONE;
      end else begin
        ex_valid <= 1'b1;
        ex_ctrl  <= id_ctrl;
        ex_rd    <= rd;
        if (id_ctrl.hlt) halted <= 1'b1;
      end
    end
  end

  assign ex_alu_op     = ex_ctrl.alu_op;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_flag_write = ex_ctrl.flag_write;
  assign ex_imm        = ex_ctrl.imm;
  assign ex_shift      = ex_ctrl.shift;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_br         = ex_ctrl.br;
  assign ex_pcs        = ex_ctrl.pcs;
  assign ex_hlt        = ex_ctrl.hlt;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench: the driver advances a reference model and queues the
// expected observation; a negedge monitor pops and compares it with the DUT.
module tb_decode_ctrl_pipe;

  localparam int REG_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Control flag bit positions in the model's 11-bit flag word.
  localparam logic [10:0] RW  = 11'h400, MR = 11'h200, MW = 11'h100, M2R = 11'h080;
  localparam logic [10:0] FW  = 11'h040, IMM = 11'h020, SH = 11'h010, BRA = 11'h008;
  localparam logic [10:0] BRR = 11'h004, PCS = 11'h002, HLT = 11'h001;

  logic             clk = 1'b0;
  logic             rst, id_valid, stall_ext, flush;
  logic [3:0]       opcode;
  logic [REG_W-1:0] rs, rt, rd;
  logic             stall_id, ex_valid, halted;
  logic [3:0]       ex_alu_op;
  logic             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_flag_write;
  logic             ex_imm, ex_shift, ex_branch, ex_br, ex_pcs, ex_hlt;
  logic [REG_W-1:0] ex_rd;
  logic [CNT_W-1:0] bubble_cnt;

  decode_ctrl_pipe #(.REG_W(REG_W), .CNT_W(CNT_W), .HAZ_EN(1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .stall_ext(stall_ext), .flush(flush),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_flag_write(ex_flag_write), .ex_imm(ex_imm),
    .ex_shift(ex_shift), .ex_branch(ex_branch), .ex_br(ex_br), .ex_pcs(ex_pcs),
    .ex_hlt(ex_hlt), .ex_rd(ex_rd), .halted(halted), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             st;
    logic             v;
    logic [3:0]       alu;
    logic [10:0]      fl;
    logic [REG_W-1:0] rd;
    logic             h;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  obs_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state (what EX should hold after the latest edge).
  logic             m_v;
  logic [3:0]       m_alu;
  logic [10:0]      m_fl;
  logic [REG_W-1:0] m_rd;
  logic             m_h;
  int               m_cnt;

  // Opcode table: {alu_op, flags}.
  function automatic logic [14:0] dec(input logic [3:0] op);
    case (op)
      4'h0: return {4'b1001, RW | FW};
      4'h1: return {4'b1010, RW | FW};
      4'h2: return {4'b0000, RW};
      4'h3: return {4'b1011, RW | FW};
      4'h4: return {4'b0100, RW | FW | IMM | SH};
      4'h5: return {4'b0001, RW | FW | IMM | SH};
      4'h6: return {4'b0010, RW | FW | IMM | SH};
      4'h7: return {4'b0011, RW};
      4'h8: return {4'b0101, RW | IMM | SH | MR | M2R};
      4'h9: return {4'b0110, IMM | MW};
      4'hA: return {4'b0111, RW | IMM};
      4'hB: return {4'b1000, RW | IMM};
      4'hC: return {4'b1111, BRA};
      4'hD: return {4'b1111, BRR};
      4'hE: return {4'b1111, RW | PCS};
      default: return {4'b1111, HLT};
    endcase
  endfunction

  function automatic logic urt(input logic [3:0] op);
    return (op == 4'h0) || (op == 4'h1) || (op == 4'h2) || (op == 4'h3) ||
           (op == 4'h7) || (op == 4'h9);
  endfunction

  task automatic bub();
    m_v = 1'b0; m_alu = 4'hF; m_fl = '0; m_rd = '0;
  endtask

  // Apply one cycle of inputs, queue the expectation, then advance the model.
  task automatic step(input logic r, input logic idv, input logic [3:0] op,
                      input logic [REG_W-1:0] s, input logic [REG_W-1:0] t,
                      input logic [REG_W-1:0] d, input logic sx, input logic fl,
                      input bit chk = 1'b1);
    logic haz;
    rst = r; id_valid = idv; opcode = op; rs = s; rt = t; rd = d;
    stall_ext = sx; flush = fl;
    haz = idv && m_v && m_fl[9] && (m_rd != '0) &&
          ((s == m_rd) || (urt(op) && (t == m_rd))) && !m_h;
    if (chk)
      expq.push_back('{st: haz && !fl, v: m_v, alu: m_alu, fl: m_fl, rd: m_rd,
                       h: m_h, cnt: CNT_W'(m_cnt)});
    @(posedge clk);
    if (r) begin
      bub(); m_h = 1'b0; m_cnt = 0;
    end else if (!sx) begin
      if (fl || m_h || haz || !idv) begin
        bub();
        if (haz && !fl && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end else begin
        {m_alu, m_fl} = dec(op);
        m_v  = 1'b1;
        m_rd = d;
        if (m_fl[0]) m_h = 1'b1;
      end
    end
    #1;
  endtask

  task automatic ins(input logic [3:0] op, input logic [REG_W-1:0] s,
                     input logic [REG_W-1:0] t, input logic [REG_W-1:0] d);
    step(1'b0, 1'b1, op, s, t, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_rst();
    step(1'b1, 1'b0, 4'h0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: each negedge compares the DUT against the oldest expectation.
  obs_t act, e;
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      e   = expq.pop_front();
      act = '{st: stall_id, v: ex_valid, alu: ex_alu_op,
              fl: {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_flag_write,
                   ex_imm, ex_shift, ex_branch, ex_br, ex_pcs, ex_hlt},
              rd: ex_rd, h: halted, cnt: bubble_cnt};
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL pipe_state t=%0t: got st=%b v=%b alu=%b fl=%b rd=%0d h=%b cnt=%0d, expected st=%b v=%b alu=%b fl=%b rd=%0d h=%b cnt=%0d",
                 $time, act.st, act.v, act.alu, act.fl, act.rd, act.h, act.cnt,
                 e.st, e.v, e.alu, e.fl, e.rd, e.h, e.cnt);
      end
    end
  end

  initial begin
    logic [3:0]       op;
    logic [REG_W-1:0] s, t, d;
    step(1'b1, 1'b0, 4'h0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    do_rst();

    // ADD rd=3 lands in EX one cycle later.
    ins(4'h0, 4'd1, 4'd2, 4'd3); idle();

    // LW rd=5 then dependent SUB: one bubble, then SUB loads.
    ins(4'h8, 4'd1, 4'd0, 4'd5); ins(4'h1, 4'd5, 4'd2, 4'd6);
    ins(4'h1, 4'd5, 4'd2, 4'd6); idle(); idle();

    // No hazard for r0, nor for rt of an opcode that does not read rt.
    ins(4'h8, 4'd1, 4'd0, 4'd0); ins(4'h0, 4'd0, 4'd1, 4'd2);
    ins(4'h8, 4'd1, 4'd0, 4'd5); ins(4'hA, 4'd1, 4'd5, 4'd7); idle();

    // SW held in EX by three external stall cycles.
    ins(4'h9, 4'd1, 4'd2, 4'd0);
    repeat (3) step(1'b0, 1'b1, 4'h0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
    idle();

    // Hazard held through stall_ext is counted once.
    do_rst();
    ins(4'h8, 4'd1, 4'd0, 4'd5);
    repeat (2) step(1'b0, 1'b1, 4'h1, 4'd5, 4'd2, 4'd6, 1'b1, 1'b0);
    ins(4'h1, 4'd5, 4'd2, 4'd6); ins(4'h1, 4'd5, 4'd2, 4'd6); idle();

    // Five hazards saturate a 2-bit counter at 3.
    do_rst();
    repeat (5) begin ins(4'h8, 4'd1, 4'd0, 4'd5); ins(4'h1, 4'd2, 4'd5, 4'd6); end
    idle();

    // Flushed HLT is dropped; real HLT halts; later work is bubbled until reset.
    step(1'b0, 1'b1, 4'hF, '0, '0, '0, 1'b0, 1'b1);
    ins(4'hF, '0, '0, '0);
    repeat (3) ins(4'h0, 4'd1, 4'd2, 4'd3);
    do_rst(); ins(4'h0, 4'd1, 4'd2, 4'd3); idle();

    // Randomized traffic over a small register range to provoke hazards.
    repeat (600) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 14));
      s = REG_W'($urandom_range(0, 3));
      t = REG_W'($urandom_range(0, 3));
      d = REG_W'($urandom_range(0, 3));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), op, s, t, d,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    end
    idle();

    repeat (3) @(posedge clk);
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 SHALL have parameter REG_W, default 4, meaning register-specifier width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning hazard-bubble counter width.
REQ-003 SHALL have parameter HAZ_EN, default 1, meaning 1 enables load-use detection and 0 disables it (stall_id is then tied 0).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 id_valid  in  1  ID-stage instruction valid.
REQ-007 opcode  in  4  ID-stage opcode.
REQ-008 rs, rt, rd  in  REG_W each  ID-stage register specifiers.
REQ-009 stall_ext  in  1  downstream (memory) stall; holds the EX register.
REQ-010 flush  in  1  taken branch; kills the ID instruction.
REQ-011 stall_id  out  1  combinational load-use stall request to fetch/ID.
REQ-012 ex_valid  out  1  EX register holds a real instruction.
REQ-013 ex_alu_op  out  4  registered ALU operation.
REQ-014 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_flag_write, ex_imm, ex_shift, ex_branch, ex_br, ex_pcs, ex_hlt  out  1 each  registered controls.
REQ-015 ex_rd  out  REG_W  registered destination specifier.
REQ-016 halted  out  1  sticky halt status.
REQ-017 bubble_cnt  out  CNT_W  saturating count of hazard bubbles.

Function
REQ-018 Decode (opcode: alu_op, asserted controls) SHALL be: 0 ADD 1001 RW FW; 1 SUB 1010 RW FW; 2 RED 0000 RW; 3 XOR 1011 RW FW; 4 SLL 0100 RW FW IMM SHIFT; 5 SRA 0001 RW FW IMM SHIFT; 6 ROR 0010 RW FW IMM SHIFT.
REQ-019 Decode continued: 7 PADDSB 0011 RW; 8 LW 0101 RW IMM SHIFT MR M2R; 9 SW 0110 IMM MW; A LHB 0111 RW IMM; B LLB 1000 RW IMM; C B BRANCH; D BR BR; E PCS RW PCS; F HLT HLT. Opcodes C-F SHALL use alu_op 1111.
REQ-020 A bubble SHALL have ex_valid=0, ex_alu_op=1111, ex_rd=0, and every other ex_* control 0.
REQ-021 uses_rt SHALL be 1 for opcodes 0, 1, 2, 3, 7 and 9, and 0 otherwise.
REQ-022 hazard SHALL equal HAZ_EN & id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((rs==ex_rd) | (uses_rt & rt==ex_rd)) & !halted.
REQ-023 stall_id SHALL equal hazard & !flush, combinationally, with zero latency.
REQ-024 Per-edge priority SHALL be, highest first: rst; stall_ext (hold EX register, halted and bubble_cnt); flush (load bubble); halted (load bubble); hazard (load bubble, bubble_cnt+1); !id_valid (load bubble); else load the decoded ID instruction with ex_valid=1.
REQ-025 Decode-to-EX latency SHALL be exactly 1 cycle.
REQ-026 halted SHALL set on the same edge that loads an HLT with ex_valid=1, and SHALL clear only on rst.
REQ-027 flush in the same cycle as an ID HLT SHALL discard the HLT, leaving halted unchanged.
REQ-028 bubble_cnt SHALL saturate at all-ones and never wrap.
REQ-029 A hazard held through stall_ext SHALL be counted once, on the edge where it is actually inserted.

Reset
REQ-030 On rst at a clock edge, all ex_* outputs SHALL take bubble values, halted=0 and bubble_cnt=0.
REQ-031 rst asserted mid-stall or mid-halt SHALL override both.

Structure
REQ-032 Opcode constants, the ALU_OP encodings and the bubble value SHALL live in shared package isa_pkg.
REQ-033 The combinational opcode-to-control table SHALL be sub-module ctrl_decode, instantiated once.

Verification
REQ-034 Reset, then ADD (op 0, rd=3) valid -> next cycle ex_valid=1, ex_alu_op=1001, ex_reg_write=1, ex_flag_write=1, ex_rd=3.
REQ-035 LW rd=5 in EX, ID SUB rs=5 -> stall_id=1; next cycle bubble; bubble_cnt 0->1; SUB loads on the following cycle.
REQ-036 LW rd=0 in EX, ID ADD rs=0 -> stall_id=0, no bubble; LW rd=5 with ID LHB rt=5 (uses_rt=0, rs!=5) -> no stall.
REQ-037 HLT with flush=1 -> bubble, halted=0; HLT alone -> ex_hlt=1 and halted=1 together; later ADD -> bubbles until rst.
REQ-038 stall_ext=1 for 3 cycles with SW in EX -> EX outputs unchanged for all 3; with CNT_W=2 and 5 hazards -> bubble_cnt=3.
